huff_seq_ctrl: RTL and testbench

- Top-level phase sequencer for the Huffman path.
- Runs one job as four ordered phases: frequency count, tree build, VLC table build, encode.
- Each phase gets a one-cycle start pulse. The controller then waits for that sub-block's level done, and a per-phase watchdog bounds the wait.
- Also drives the ownership selects for the shared tree RAM and the VLC-table read ports, so sub-blocks never contend.

---
 rtl/huff_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_huff_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/huff_seq_ctrl.sv
// ---------------------------------------------------------------------------
// huff_seq_ctrl
//   Phase sequencer for the Huffman path. A job runs four ordered phases:
//   frequency count, tree build, VLC table build and encode. Each phase is
//   split into ISSUE (one-cycle start pulse), BLANK (the sub-block done is
//   ignored, which masks a stale level left over from the previous run) and
//   WAIT (done is sampled). A per-phase watchdog bounds WAIT. The block also
//   owns the tree-RAM and VLC-read-port selects, so sub-blocks never contend.
//
// Ports
//   clk, rstN                 clock, asynchronous active-low reset
//   job_start, job_abort      job control pulses (abort has priority)
//   freq/tree/vlc/enc_done    level done from each sub-block
//   freq/tree/vlc/enc_start   one-cycle start pulses
//   tree_ram_own [1:0]        0 none, 1 tree builder, 2 vlc_table
//   vlc_rd_own                1 while the encoder drives the VLC read ports
//   phase [2:0]               0 IDLE 1 FREQ 2 TREE 3 VLC 4 ENC 5 FIN 6 ERR
//   job_busy, job_done, job_err, err_phase [2:0], job_cycles [31:0]
// ---------------------------------------------------------------------------
module huff_seq_ctrl #(
    parameter int unsigned      BLANK_CYC = 2,
    parameter int unsigned      TO_W      = 20,
    parameter logic [TO_W-1:0]  TO_MAX    = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        job_start,
    input  logic        job_abort,
    input  logic        freq_done,
    input  logic        tree_done,
    input  logic        vlc_done,
    input  logic        enc_done,
    output logic        freq_start,
    output logic        tree_start,
    output logic        vlc_start,
    output logic        enc_start,
    output logic [1:0]  tree_ram_own,
    output logic        vlc_rd_own,
    output logic [2:0]  phase,
    output logic        job_busy,
    output logic        job_done,
    output logic        job_err,
    output logic [2:0]  err_phase,
    output logic [31:0] job_cycles
);

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_FREQ = 3'd1,
        PH_TREE = 3'd2,
        PH_VLC  = 3'd3,
        PH_ENC  = 3'd4,
        PH_FIN  = 3'd5,
        PH_ERR  = 3'd6
    } phase_e;

    typedef enum logic [1:0] {
        SUB_ISSUE = 2'd0,
        SUB_BLANK = 2'd1,
        SUB_WAIT  = 2'd2
    } sub_e;

    localparam int unsigned     BW         = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0]   BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    phase_e            phase_q, phase_d;
    sub_e              sub_q, sub_d;
    logic [BW-1:0]     blank_q, blank_d;
    logic [TO_W-1:0]   wd_q, wd_d;
    logic [31:0]       cyc_q, cyc_d;
    logic [2:0]        err_phase_q, err_phase_d;

    logic              work;
    logic              done_sel;
    logic              timeout_hit;
    logic [TO_W:0]     wd_cur;
    phase_e            phase_next;

    assign work = (phase_q == PH_FREQ) || (phase_q == PH_TREE) ||
                  (phase_q == PH_VLC)  || (phase_q == PH_ENC);

    // wd_q counts completed cycles of the phase (0 in ISSUE), so wd_cur is the
    // cycle number of the current cycle counted from phase entry.
    assign wd_cur      = {1'b0, wd_q} + (TO_W+1)'(1);
    assign timeout_hit = (wd_cur >= {1'b0, TO_MAX});

    always_comb begin
        done_sel   = 1'b0;
        phase_next = PH_IDLE;
        unique case (phase_q)
            PH_FREQ: begin done_sel = freq_done; phase_next = PH_TREE; end
            PH_TREE: begin done_sel = tree_done; phase_next = PH_VLC;  end
            PH_VLC:  begin done_sel = vlc_done;  phase_next = PH_ENC;  end
            PH_ENC:  begin done_sel = enc_done;  phase_next = PH_FIN;  end
            default: begin done_sel = 1'b0;      phase_next = PH_IDLE; end
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        phase_d     = phase_q;
        sub_d       = sub_q;
        blank_d     = blank_q;
        wd_d        = (wd_q == '1) ? wd_q : wd_q + TO_W'(1);
        cyc_d       = (work && (cyc_q != '1)) ? cyc_q + 32'd1 : cyc_q;
        err_phase_d = err_phase_q;

        if (job_abort) begin
            phase_d = PH_IDLE;
            sub_d   = SUB_ISSUE;
            blank_d = '0;
            wd_d    = '0;
        end else if (!work) begin
            wd_d = '0;
            if (job_start) begin
                phase_d     = PH_FREQ;
                sub_d       = SUB_ISSUE;
                blank_d     = '0;
                err_phase_d = 3'd0;
                cyc_d       = '0;
            end else if (phase_q == PH_FIN) begin
                phase_d = PH_IDLE;
            end
        end else begin
            unique case (sub_q)
                SUB_ISSUE: begin
                    sub_d   = (BLANK_CYC == 0) ? SUB_WAIT : SUB_BLANK;
                    blank_d = '0;
                end
                SUB_BLANK: begin
                    if (blank_q == BLANK_LAST) sub_d = SUB_WAIT;
                    else                       blank_d = blank_q + BW'(1);
                end
                SUB_WAIT: begin
                    // A done arriving in the timeout cycle still advances.
                    if (done_sel) begin
                        phase_d = phase_next;
                        sub_d   = SUB_ISSUE;
                        wd_d    = '0;
                    end else if (timeout_hit) begin
                        phase_d     = PH_ERR;
                        sub_d       = SUB_ISSUE;
                        wd_d        = '0;
                        err_phase_d = phase_q;
                    end
                end
                default: sub_d = SUB_ISSUE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            phase_q     <= PH_IDLE;
            sub_q       <= SUB_ISSUE;
            blank_q     <= '0;
            wd_q        <= '0;
            cyc_q       <= '0;
            err_phase_q <= 3'd0;
        end else begin
            phase_q     <= phase_d;
            sub_q       <= sub_d;
            blank_q     <= blank_d;
            wd_q        <= wd_d;
            cyc_q       <= cyc_d;
            err_phase_q <= err_phase_d;
        end
    end

    // Outputs decode straight from the registered state: owner selects switch
    // in the ISSUE cycle together with the start pulse, and drop the instant
    // rstN asserts.
    logic issue;
    assign issue = (sub_q == SUB_ISSUE);

    assign freq_start   = (phase_q == PH_FREQ) && issue;
    assign tree_start   = (phase_q == PH_TREE) && issue;
    assign vlc_start    = (phase_q == PH_VLC)  && issue;
    assign enc_start    = (phase_q == PH_ENC)  && issue;
    assign tree_ram_own = (phase_q == PH_TREE) ? 2'd1 :
                          (phase_q == PH_VLC)  ? 2'd2 : 2'd0;
    assign vlc_rd_own   = (phase_q == PH_ENC);
    assign phase        = phase_q;
    assign job_busy     = work;
    assign job_done     = (phase_q == PH_FIN);
    assign job_err      = (phase_q == PH_ERR);
    assign err_phase    = err_phase_q;
    assign job_cycles   = cyc_q;

endmodule

// File: tb/tb_huff_seq_ctrl.sv
module tb_huff_seq_ctrl;

    localparam int TO = 50;

    logic        clk;
    logic        rstN;
    logic        job_start, job_abort;
    logic        freq_done, tree_done, vlc_done, enc_done;
    logic        freq_start, tree_start, vlc_start, enc_start;
    logic [1:0]  tree_ram_own;
    logic        vlc_rd_own;
    logic [2:0]  phase;
    logic        job_busy, job_done, job_err;
    logic [2:0]  err_phase;
    logic [31:0] job_cycles;

    int checks = 0;
    int errors = 0;

    huff_seq_ctrl #(
        .BLANK_CYC (2),
        .TO_W      (20),
        .TO_MAX    (20'd50)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .job_start    (job_start),
        .job_abort    (job_abort),
        .freq_done    (freq_done),
        .tree_done    (tree_done),
        .vlc_done     (vlc_done),
        .enc_done     (enc_done),
        .freq_start   (freq_start),
        .tree_start   (tree_start),
        .vlc_start    (vlc_start),
        .enc_start    (enc_start),
        .tree_ram_own (tree_ram_own),
        .vlc_rd_own   (vlc_rd_own),
        .phase        (phase),
        .job_busy     (job_busy),
        .job_done     (job_done),
        .job_err      (job_err),
        .err_phase    (err_phase),
        .job_cycles   (job_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] obs_vec();
        return {phase, freq_start, tree_start, vlc_start, enc_start,
                tree_ram_own, vlc_rd_own, job_busy, job_done, job_err};
    endfunction

    // Expected outputs for a cycle spent in phase code ph; first marks the
    // phase's opening (ISSUE) cycle.
    function automatic logic [12:0] exp_vec(input int ph, input bit first);
        logic [2:0] p3;
        logic [1:0] own;
        p3  = 3'(ph);
        own = (ph == 2) ? 2'd1 : (ph == 3) ? 2'd2 : 2'd0;
        return {p3, (ph == 1) && first, (ph == 2) && first, (ph == 3) && first,
                (ph == 4) && first, own, ph == 4, (ph >= 1) && (ph <= 4),
                ph == 5, ph == 6};
    endfunction

    // One job from the model's point of view. d[p] is the number of WAIT
    // cycles phase p sees done low; stale[p] is the done level during its
    // ISSUE/BLANK cycles. A phase therefore lasts 4 + d[p] cycles, unless it
    // is still waiting after TO cycles, in which case ERR starts TO cycles
    // after its start pulse. Cycle 0 is the job_start cycle. ghost >= 0 puts
    // a stray job_start in the first WAIT cycle of that phase. abort_at and
    // stop_at are absolute cycles (-1 = unused).
    task automatic run_job(input int d[4], input logic [3:0] stale, input int ghost,
                           input int abort_at, input int stop_at);
        int s[5];
        int err_p, err_cyc, fin, last, lim, cur, ph, o;
        bit first, in_work;
        logic dn[4];
        err_p = -1; err_cyc = 0; fin = 0;
        s[0] = 1;
        for (int p = 0; p < 4; p++) begin
            if (err_p < 0) begin
                if (d[p] >= TO - 3) begin
                    err_p   = p;
                    err_cyc = s[p] + TO;
                end else begin
                    s[p+1] = s[p] + 4 + d[p];
                end
            end
        end
        if (err_p < 0) fin = s[4];
        last = (err_p >= 0) ? err_cyc + 3 : fin + 1;
        if (abort_at >= 0) last = abort_at + 2;
        if (stop_at >= 0 && stop_at < last) last = stop_at;
        lim = (err_p >= 0) ? err_p : 3;

        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            in_work = 1'b0; cur = 0; o = 0; first = 1'b0; ph = 0;
            if (k >= 1) begin
                if (abort_at >= 0 && k > abort_at)      ph = 0;
                else if (err_p >= 0 && k >= err_cyc)    ph = 6;
                else if (err_p < 0 && k == fin)         ph = 5;
                else if (err_p < 0 && k > fin)          ph = 0;
                else begin
                    for (int p = 1; p <= lim; p++) if (k >= s[p]) cur = p;
                    in_work = 1'b1;
                    o       = k - s[cur];
                    first   = (o == 0);
                    ph      = cur + 1;
                end
                check("seq", 64'(obs_vec()), 64'(exp_vec(ph, first)));
                if (k == 1) check("err_phase_clr", 64'(err_phase), 64'd0);
                if (ph == 5) check("cycles_fin", 64'(job_cycles), 64'(fin - 1));
                if (ph == 6) begin
                    check("err_phase", 64'(err_phase), 64'(err_p + 1));
                    check("cycles_err", 64'(job_cycles), 64'(err_cyc - 1));
                end
            end
            job_start = (k == 0) || (ghost >= 0 && in_work && cur == ghost && o == 3);
            job_abort = (k == abort_at);
            for (int i = 0; i < 4; i++) dn[i] = 1'($urandom);
            if (in_work) dn[cur] = (o < 3) ? stale[cur] : ((o - 3) >= d[cur]);
            freq_done = dn[0]; tree_done = dn[1]; vlc_done = dn[2]; enc_done = dn[3];
        end
    endtask

    initial begin
        int dr[4];
        rstN = 1'b0; job_start = 1'b0; job_abort = 1'b0;
        freq_done = 1'b0; tree_done = 1'b0; vlc_done = 1'b0; enc_done = 1'b0;
        #1;
        check("reset", 64'({obs_vec(), err_phase, job_cycles}), 64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // Nominal: starts at 1/5/9/13, job_done at 17, job_cycles 16, IDLE at 18.
        run_job('{0, 0, 0, 0}, 4'hF, -1, -1, -1);
        // Stale done on VLC, then 10 low WAIT cycles: VLC lasts 14 cycles.
        run_job('{0, 0, 10, 0}, 4'hF, -1, -1, -1);
        // Stray job_start in VLC WAIT is ignored.
        run_job('{1, 2, 4, 0}, 4'hF, 2, -1, -1);
        // Randomised done latencies and stale levels.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 4; i++) dr[i] = int'($urandom_range(0, 6));
            run_job(dr, 4'($urandom), -1, -1, -1);
        end
        // Done in the watchdog's last cycle wins; one cycle later it times out.
        run_job('{0, 46, 0, 0}, 4'h0, -1, -1, -1);
        run_job('{0, 47, 0, 0}, 4'h0, -1, -1, -1);
        // Restart out of ERR.
        run_job('{0, 0, 0, 0}, 4'hF, -1, -1, -1);
        // FREQ timeout, then VLC timeout aborted from ERR (ERR entered at 59).
        run_job('{1000, 0, 0, 0}, 4'h0, -1, -1, -1);
        run_job('{0, 0, 1000, 0}, 4'h0, -1, 61, -1);
        // Abort in ENC BLANK: IDLE next cycle, no job_done.
        run_job('{0, 0, 0, 0}, 4'hF, -1, 15, -1);

        // Simultaneous start and abort in IDLE: stays IDLE.
        @(negedge clk);
        job_start = 1'b1; job_abort = 1'b1;
        @(negedge clk);
        check("start_abort_0", 64'(obs_vec()), 64'd0);
        job_start = 1'b0; job_abort = 1'b0;
        @(negedge clk);
        check("start_abort_1", 64'(obs_vec()), 64'd0);

        // Reset in TREE WAIT (cycle 10): outputs drop without a clock edge.
        run_job('{0, 10, 0, 0}, 4'hF, -1, -1, 10);
        #2 rstN = 1'b0;
        #1 check("mid_reset", 64'({obs_vec(), err_phase, job_cycles}), 64'd0);
        @(negedge clk);
        check("mid_reset_hold", 64'({obs_vec(), err_phase, job_cycles}), 64'd0);
        rstN = 1'b1;
        run_job('{0, 0, 0, 0}, 4'hF, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
